// File: rtl/mx_rx_frame_buf_if.sv
// Bus bundle for mx_rx_frame_buf: receiver byte stream in, host read side out.
// master = traffic source / host, slave = the frame buffer.
interface mx_rx_frame_buf_if #(
    parameter int DEPTH = 64
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          cardet;
    logic [7:0]    rx_data;
    logic          rx_write;
    logic          rx_error;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic [PW-1:0] frame_len;
    logic          overflow;
    logic [7:0]    drop_cnt;

    modport master (
        output cardet, rx_data, rx_write, rx_error, rd_en,
        input  rd_data, rd_valid, frame_ready, frame_len, overflow, drop_cnt
    );

    modport slave (
        input  cardet, rx_data, rx_write, rx_error, rd_en,
        output rd_data, rd_valid, frame_ready, frame_len, overflow, drop_cnt
    );
endinterface

// File: rtl/mx_rx_frame_buf.sv
// Single-frame receive buffer behind mx_rcvr. Captures one cardet-delimited
// frame into RAM, presents it to the host via rd_en/rd_data, and discards
// errored or oversized frames (counting them in drop_cnt).
// Optional build macro MX_RXBUF_ADDR_FILTER_EN: drop frames whose first byte
// is neither MY_ADDR nor broadcast 8'hFF, without counting them.
module mx_rx_frame_buf #(
    parameter int         DEPTH   = 64,
    parameter logic [7:0] MY_ADDR = 8'h2A
) (
    input  logic               clk,
    input  logic               rst,
    mx_rx_frame_buf_if.slave   bus
);
    localparam int PW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RECV, HOLD, DROP} state_t;

    state_t        state, state_nx;
    logic          cardet_q, cardet_prev;
    logic          rise, fall;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, wr_nx, rd_ptr, len_q;
    logic [7:0]    rd_data_q, drop_q;
    logic          rd_valid_q, ready_q, ovf_q;
    logic          store, inc_drop, set_ovf, load_hold, rd_fire, rd_last;
    logic          addr_bad;

    assign rise    = cardet_q & ~cardet_prev;
    assign fall    = ~cardet_q & cardet_prev;
    assign wr_nx   = wr_ptr + PW'(store);
    assign rd_last = (rd_ptr + PW'(1)) == len_q;

`ifdef MX_RXBUF_ADDR_FILTER_EN
    assign addr_bad = bus.rx_write && (wr_ptr == '0) &&
                      (bus.rx_data != MY_ADDR) && (bus.rx_data != 8'hFF);
`else
    // Station address only matters when the filter is built in.
    logic [7:0] unused_my_addr;
    assign unused_my_addr = MY_ADDR;
    assign addr_bad       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nx  = state;
        store     = 1'b0;
        inc_drop  = 1'b0;
        set_ovf   = 1'b0;
        load_hold = 1'b0;
        rd_fire   = 1'b0;
        case (state)
            IDLE: if (rise) state_nx = RECV;
            RECV: begin
                if (bus.rx_error) begin
                    // Error wins even over a byte arriving in the same cycle.
                    state_nx = DROP;
                    inc_drop = 1'b1;
                end else if (bus.rx_write && (wr_ptr == PW'(DEPTH))) begin
                    state_nx = DROP;
                    set_ovf  = 1'b1;
                    inc_drop = 1'b1;
                end else if (addr_bad) begin
                    state_nx = DROP;
                end else begin
                    store = bus.rx_write;
                    // A byte coinciding with the fall is part of the frame.
                    if (fall) begin
                        if (wr_nx != '0) begin
                            state_nx  = HOLD;
                            load_hold = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.rd_en) begin
                    rd_fire = 1'b1;
                    if (rd_last) state_nx = IDLE;
                end
                // No room for a second frame: it is lost, once per carrier.
                if (rise) inc_drop = 1'b1;
            end
            DROP: if (!cardet_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame RAM write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr[PW-2:0]] <= bus.rx_data;
    end

    // Carrier sync, pointers, host outputs and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Sync flops come up "high" so a carrier already present at
            // release is not mistaken for a rise; a low carrier just reads
            // as a fall, which IDLE ignores.
            cardet_q    <= 1'b1;
            cardet_prev <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ready_q     <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            cardet_q    <= bus.cardet;
            cardet_prev <= cardet_q;
            rd_valid_q  <= rd_fire;
            if (state == IDLE) wr_ptr <= '0;
            else if (store)    wr_ptr <= wr_nx;
            if (load_hold) begin
                len_q   <= wr_nx;
                ready_q <= 1'b1;
                rd_ptr  <= '0;
            end
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr[PW-2:0]];
                rd_ptr    <= rd_ptr + PW'(1);
                if (rd_last) ready_q <= 1'b0;
            end
            if (set_ovf)                    ovf_q <= 1'b1;
            else if (state == IDLE && rise) ovf_q <= 1'b0;
            if (inc_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_ready = ready_q;
    assign bus.frame_len   = len_q;
    assign bus.overflow    = ovf_q;
    assign bus.drop_cnt    = drop_q;
endmodule

// File: doc/mx_rx_frame_buf.md
# mx_rx_frame_buf

Receive-side frame buffer that sits directly downstream of `mx_rcvr`. It consumes the receiver's byte stream (`data`/`write`/`error`/`cardet`) and stores one complete frame in an internal RAM. The frame is delimited by `cardet` falling. Once complete, the frame is exposed to the host through a read handshake together with its byte count and status. Errored, oversized or (optionally) mis-addressed frames are discarded and counted.

## Interface
Parameters:
- `DEPTH`, 64, frame RAM depth in bytes; power of 2, 4..128.
- `MY_ADDR`, 8'h2A, station address; used only with `MX_RXBUF_ADDR_FILTER_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `cardet` in 1: carrier detect from `mx_rcvr`.
- `rx_data` in 8: received byte, valid when `rx_write` is high.
- `rx_write` in 1: one-cycle strobe per received byte.
- `rx_error` in 1: receiver error strobe.
- `rd_en` in 1: host read request, one byte per cycle.
- `rd_data` out 8: read byte.
- `rd_valid` out 1: `rd_data` valid, one-cycle pulse.
- `frame_ready` out 1: a complete, good frame is held.
- `frame_len` out $clog2(DEPTH)+1: byte count of the held frame.
- `overflow` out 1: sticky; the last frame exceeded `DEPTH`. Cleared on the next `cardet` rise.
- `drop_cnt` out 8: saturating count of discarded frames.

## Operation
- `cardet` is registered once internally. Edges are detected on that registered copy.
- FSM states: IDLE, RECV, HOLD, DROP.
- IDLE:
  - `cardet` rise -> RECV.
  - Write pointer = 0; `overflow` cleared.
- RECV:
  - Each `rx_write` stores `rx_data` at the write pointer and increments it.
  - `rx_error` -> DROP; `drop_cnt`++.
  - `rx_write` with pointer == DEPTH -> set `overflow`, go to DROP, `drop_cnt`++.
  - `cardet` fall with pointer > 0 -> HOLD; `frame_len` = pointer, `frame_ready` = 1.
  - `cardet` fall with pointer == 0 -> IDLE; not counted.
- DROP: ignore all input until `cardet` low, then IDLE.
- HOLD:
  - `rd_en` returns the byte at the read pointer and increments the pointer.
  - The read that returns byte `frame_len-1` drops `frame_ready` and moves to IDLE in that same cycle.
  - `rd_en` while not in HOLD is ignored; no `rd_valid`.
  - A `cardet` rise during HOLD does not start reception. That frame is lost and `drop_cnt`++ once per rise.
- Simultaneous events:
  - `rx_write` in the same cycle as the registered `cardet` fall: the byte is stored and counted in `frame_len`.
  - `rx_error` in the same cycle as `rx_write`: error wins; the frame is dropped.
- `drop_cnt` saturates at 255.
- Pointer width is $clog2(DEPTH)+1 so that a count of DEPTH is representable.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0, `frame_ready` = 0, `frame_len` = 0, `overflow` = 0, `drop_cnt` = 0.
  - FSM in IDLE.
- Read latency: `rd_en` sampled high in cycle N -> `rd_data`/`rd_valid` in cycle N+1.
- Back-to-back `rd_en` gives one byte per cycle.
- `frame_ready` rises 2 cycles after `cardet` falls at the pin: 1 cycle sync + 1 cycle FSM.
- `frame_len` is stable whenever `frame_ready` = 1.
- Reset asserted mid-frame or mid-read:
  - All state clears immediately, including `drop_cnt`.
  - After release, the block waits for a fresh `cardet` rise. A `cardet` already high at release is not treated as a rise.

## Configuration
- `MX_RXBUF_ADDR_FILTER_EN` defined:
  - The first stored byte of each frame is compared with `MY_ADDR` and 8'hFF (broadcast).
  - On mismatch, go to DROP silently; `drop_cnt` is not incremented.
- `MX_RXBUF_ADDR_FILTER_EN` undefined: every good frame is held; `MY_ADDR` is unused.

## Test plan
- Good frame:
  - Stimulus: drive bytes 2A,11,22,33, then `cardet` low.
  - Required: `frame_ready`=1 and `frame_len`=4; four `rd_en` pulses return 2A,11,22,33 each 1 cycle later; `frame_ready`=0 after the 4th read.
- Receiver error:
  - Stimulus: 3 bytes, then an `rx_error` pulse, then `cardet` low.
  - Required: `frame_ready` stays 0, `drop_cnt`=1, next good frame received normally.
- Overflow:
  - Stimulus: DEPTH+1 = 65 `rx_write` strobes.
  - Required: `overflow`=1, no frame held, `drop_cnt`=1; `overflow` clears on the next `cardet` rise.
- Frame arrives while HOLD:
  - Stimulus: second frame while the first is unread.
  - Required: first frame intact on readout, `drop_cnt`=1.
- Async reset mid-read:
  - Stimulus: assert `rst` low after 2 of 4 reads.
  - Required: all outputs return to reset values immediately; a new frame is then accepted.
- Address filter (with `MX_RXBUF_ADDR_FILTER_EN`):
  - Stimulus: frames whose first byte is 2A, FF and 05.
  - Required: first two are held; the third is discarded with `drop_cnt` unchanged.
